multi_cycle_add_sub: RTL
========================

Name: multi_cycle_add_sub

Overview:
- Parametrised, digit-serial successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per cycle, chaining a registered carry between digits.
- Produces the result plus N/Z/C/V flags for the LEGv8 ALU/flag path.
- Uses a start/busy/done handshake so the datapath can trade latency for adder area.

Parameters:
- WIDTH, 64, operand/result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH exactly; 1 <= DIGIT <= WIDTH. Elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result/flags just updated
- result  output  WIDTH  sum/difference, held until next done
- flag_n  output  1  result[WIDTH-1]
- flag_z  output  1  result == 0
- flag_c  output  1  carry out of MSB; for sub, 1 = no borrow (ARM convention)
- flag_v  output  1  signed overflow = carry-into-MSB XOR carry-out

Behaviour:
- Define NDIG = WIDTH/DIGIT.
- Reset (synchronous, dominant over all other inputs): state=IDLE; busy, done, result and all flags = 0; internal operand, carry and counter registers cleared. Reset mid-operation aborts it; no done is issued.
- States: IDLE, RUN.
- IDLE + start=1 at edge E0:
  - load opA=a and opB = sub ? ~b : b;
  - carry=sub; digit counter=0; state=RUN; busy=1.
  - done deasserts at E0 if it was high.
- IDLE + start=0: hold; done=0.
- RUN, each edge:
  - add the low DIGIT bits of opA, opB and carry;
  - shift the sum digit into the partial-result register from the top (LSB digit first);
  - shift opA/opB right by DIGIT; carry <= digit carry-out; counter++.
  - On the last digit (counter==NDIG-1), also record carry-into-MSB.
- Completion, edge E_NDIG:
  - result <= full partial result; flags computed from it and registered in the same edge;
  - state=IDLE; busy=0; done=1 for exactly one cycle.
- Latency: start sampled at E0, done visible after edge E_NDIG, i.e. NDIG+1 edges. busy is high for exactly NDIG cycles.
- start while busy=1: ignored entirely. No queuing, and operands are not re-sampled.
- start in the done cycle: accepted (busy=0 then). done drops and busy rises at that edge. Back-to-back throughput is one operation per NDIG+1 cycles.
- Result/flag stability: result and flags change only at completion edges or reset. They hold their previous values throughout RUN.
- a, b and sub may change freely after E0 without affecting the operation in flight.
- Arithmetic is modulo 2^WIDTH. Carries never leak between operations, because carry is re-initialised at every load.
- DIGIT=WIDTH degenerates to NDIG=1: done appears after the edge following start.

Test Plan:
- WIDTH=8, DIGIT=2: a=0x7F, b=0x01, sub=0 -> done after 5th edge; result=0x80, N=1 Z=0 C=0 V=1; busy high exactly 4 cycles.
- WIDTH=8, DIGIT=2, sub=1: 0x05-0x05 -> result=0x00, N=0 Z=1 C=1 V=0. Then 0x00-0x01 -> result=0xFF, N=1 Z=0 C=0 V=0. Then 0x80-0x01 -> result=0x7F, V=1 C=1.
- Defaults (64/4): a=0xFFFF_FFFF_FFFF_FFFF, b=1, add -> result=0, Z=1 C=1 V=0 N=0; done after 17th edge. Also check that result holds its previous value during all 16 busy cycles.
- Handshake: pulse start again at cycles 2 and 5 of busy with different operands -> ignored, first result unchanged. Assert start in the done cycle -> new operation accepted, busy rises next cycle, second result correct.
- Reset at busy cycle 3 -> next cycle busy=0, done=0, result=0, flags=0; no done pulse later. A following operation (0x12+0x34, WIDTH=8) yields 0x46 with C=0.
- Random regression: 10k operations at DIGIT in {1, 2, 4, 8} (WIDTH=8) and {4, 64} (WIDTH=64), compared against a behavioural model for result and all four flags.

Source files
------------

// File: rtl/multi_cycle_add_sub.sv
// multi_cycle_add_sub: digit-serial add/subtract with N/Z/C/V flags and start/busy/done handshake
module multi_cycle_add_sub #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("DIGIT must divide WIDTH and lie in 1..WIDTH");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [WIDTH-1:0] opa, opb, part, nxt;
  logic carry, cin_msb;
  logic [CW-1:0] cnt;
  logic [DIGIT:0] s;
  always_comb begin
    s = {1'b0, opa[DIGIT-1:0]} + {1'b0, opb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    nxt = (WIDTH'(s[DIGIT-1:0]) << (WIDTH - DIGIT)) | (part >> DIGIT);
    cin_msb = s[DIGIT-1] ^ opa[DIGIT-1] ^ opb[DIGIT-1];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
      opa <= '0;
      opb <= '0;
      part <= '0;
      carry <= 1'b0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opa <= a;
          opb <= sub ? ~b : b;
          carry <= sub;
          cnt <= '0;
          state <= RUN;
          busy <= 1'b1;
        end
      end else begin
        opa <= opa >> DIGIT;
        opb <= opb >> DIGIT;
        carry <= s[DIGIT];
        part <= nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(NDIG - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          result <= nxt;
          flag_n <= nxt[WIDTH-1];
          flag_z <= nxt == '0;
          flag_c <= s[DIGIT];
          flag_v <= cin_msb ^ s[DIGIT];
        end
      end
    end
  end
endmodule
